// File: rtl/axis_stim_seq.sv
// Frame sequencer: launches stimulus-generator frames and counts beats/frames on a passive AXIS tap.
// Define AXIS_STIM_SEQ_WDOG_EN to enable the WAIT_LAST stall watchdog (timeout_err tied low otherwise).
module axis_stim_seq #(
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 go,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] num_frames,
   input  logic [15:0]          gap_cycles,
   output logic                 stim_start,
   input  logic                 mon_tvalid,
   input  logic                 mon_tready,
   input  logic                 mon_tlast,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 timeout_err,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [31:0]          beat_cnt
);

   typedef enum logic [2:0] {IDLE, START, WAIT_LAST, GAP, DONE} state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] frames_lat, frames_lat_nxt, frame_cnt_nxt;
   logic [15:0]          gap_lat, gap_lat_nxt, gap_cnt, gap_cnt_nxt;
   logic [31:0]          beat_cnt_nxt;
   logic                 stim_start_nxt, aborted_nxt;
   logic                 hs;

`ifdef AXIS_STIM_SEQ_WDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wdog, wdog_nxt;
   logic            to_nxt;
`endif

   assign hs = mon_tvalid & mon_tready;

   always_comb begin
      state_nxt      = state;
      frames_lat_nxt = frames_lat;
      gap_lat_nxt    = gap_lat;
      gap_cnt_nxt    = gap_cnt;
      frame_cnt_nxt  = frame_cnt;
      beat_cnt_nxt   = beat_cnt;
      aborted_nxt    = aborted;
      stim_start_nxt = 1'b0;
`ifdef AXIS_STIM_SEQ_WDOG_EN
      wdog_nxt       = wdog;
      to_nxt         = timeout_err;
`endif
      case (state)
         IDLE: begin
            if (go) begin
               frames_lat_nxt = num_frames;
               gap_lat_nxt    = gap_cycles;
               frame_cnt_nxt  = '0;
               beat_cnt_nxt   = '0;
               aborted_nxt    = 1'b0;
`ifdef AXIS_STIM_SEQ_WDOG_EN
               to_nxt         = 1'b0;
`endif
               state_nxt      = START;
            end
         end
         START: begin
`ifdef AXIS_STIM_SEQ_WDOG_EN
            wdog_nxt = '0;
`endif
            // The pulse is registered out of START, so it appears in the first WAIT_LAST cycle.
            if (abort) begin
               aborted_nxt = 1'b1;
               state_nxt   = DONE;
            end else begin
               stim_start_nxt = 1'b1;
               state_nxt      = WAIT_LAST;
            end
         end
         WAIT_LAST: begin
            if (hs)
               beat_cnt_nxt = beat_cnt + 32'd1;
            if (hs && mon_tlast)
               frame_cnt_nxt = frame_cnt + CNT_WIDTH'(1);
            if (abort) begin
               aborted_nxt = 1'b1;
               state_nxt   = DONE;
            end else if (hs && mon_tlast) begin
               if (frames_lat != '0 && frame_cnt_nxt == frames_lat)
                  state_nxt = DONE;
               else if (gap_lat == '0)
                  state_nxt = START;
               else begin
                  gap_cnt_nxt = gap_lat;
                  state_nxt   = GAP;
               end
            end
`ifdef AXIS_STIM_SEQ_WDOG_EN
            else if (hs)
               wdog_nxt = '0;
            else if (wdog == WD_W'(TIMEOUT_CYC)) begin
               to_nxt    = 1'b1;
               state_nxt = DONE;
            end else
               wdog_nxt = wdog + WD_W'(1);
`endif
         end
         GAP: begin
            if (abort) begin
               aborted_nxt = 1'b1;
               state_nxt   = DONE;
            end else begin
               gap_cnt_nxt = gap_cnt - 16'd1;
               if (gap_cnt == 16'd1)
                  state_nxt = START;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         frames_lat <= '0;
         gap_lat    <= '0;
         gap_cnt    <= '0;
         frame_cnt  <= '0;
         beat_cnt   <= '0;
         aborted    <= 1'b0;
         stim_start <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         frames_lat <= frames_lat_nxt;
         gap_lat    <= gap_lat_nxt;
         gap_cnt    <= gap_cnt_nxt;
         frame_cnt  <= frame_cnt_nxt;
         beat_cnt   <= beat_cnt_nxt;
         aborted    <= aborted_nxt;
         stim_start <= stim_start_nxt;
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == DONE);
      end
   end

`ifdef AXIS_STIM_SEQ_WDOG_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog        <= '0;
         timeout_err <= 1'b0;
      end else begin
         wdog        <= wdog_nxt;
         timeout_err <= to_nxt;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_stim_seq.sv
// Randomized bench for axis_stim_seq against a cycle-event reference model of the sequencing rules.
// Runs the stall-watchdog scenario only when AXIS_STIM_SEQ_WDOG_EN is defined.
module tb_axis_stim_seq;

   localparam int CW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0, rstn = 1'b0, go = 1'b0, abort = 1'b0;
   logic          mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
   logic [CW-1:0] num_frames = '0;
   logic [15:0]   gap_cycles = '0;
   logic          stim_start, busy, done, aborted, timeout_err;
   logic [CW-1:0] frame_cnt;
   logic [31:0]   beat_cnt;

   axis_stim_seq #(.CNT_WIDTH(CW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rstn(rstn), .go(go), .abort(abort),
      .num_frames(num_frames), .gap_cycles(gap_cycles),
      .stim_start(stim_start),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
      .busy(busy), .done(done), .aborted(aborted), .timeout_err(timeout_err),
      .frame_cnt(frame_cnt), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0;

   // reference model: expected event cycles plus running totals
   int exp_start, exp_done, m_frames, m_beats, nf_l, gap_l, stall, n_tlast, first_tlast;
   bit m_busy, m_in_frame, m_aborted, m_to;
   // stimulus generator and configuration
   int gen_left, rdy_stall;
   int cfg_lmin = 1, cfg_lmax = 1, cfg_pct = 100, abort_mode = 0, abort_n = 0, abort_pct = 0;
   bit cfg_noise = 1'b0;
   // DUT observations
   int n_start_obs, n_done_obs, start2_cyc, last_start_cyc, done_cyc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void reset_model();
      m_busy = 0; m_in_frame = 0; m_aborted = 0; m_to = 0;
      m_frames = 0; m_beats = 0; exp_start = -1; exp_done = -1;
      gen_left = 0; stall = 0; rdy_stall = 0; n_tlast = 0;
   endfunction

   task automatic step();
      int  p;
      bit  hs, busy_p, done_p, frame_p;
      @(posedge clk);
      @(negedge clk);
      p = cyc; cyc++;
      hs      = mon_tvalid && mon_tready;
      busy_p  = m_busy;
      done_p  = (exp_done == p);
      frame_p = m_in_frame;
      // effects of the inputs applied during cycle p
      if (go && !busy_p) begin
         nf_l = int'(num_frames); gap_l = int'(gap_cycles);
         m_frames = 0; m_beats = 0; m_aborted = 0; m_to = 0; n_tlast = 0;
         exp_start = p + 2; exp_done = -1; m_busy = 1;
      end else if (done_p) begin
         m_busy = 0; exp_done = -1;
      end
      if (frame_p) begin
         if (hs) begin
            m_beats++;
            if (gen_left > 0) gen_left--;
         end
         if (hs && mon_tlast) begin
            m_frames++; n_tlast++;
            if (n_tlast == 1) first_tlast = p;
            m_in_frame = 0;
            if (abort) begin m_aborted = 1; exp_done = cyc; end
            else if (nf_l != 0 && (m_frames % (1 << CW)) == nf_l) exp_done = cyc;
            else exp_start = p + 2 + gap_l;
         end else if (abort) begin
            m_in_frame = 0; m_aborted = 1; exp_done = cyc; gen_left = 0;
         end
`ifdef AXIS_STIM_SEQ_WDOG_EN
         else if (hs) stall = 0;
         else if (stall == TO) begin
            m_in_frame = 0; m_to = 1; exp_done = cyc; gen_left = 0;
         end else stall++;
`endif
      end else if (busy_p && !done_p && abort) begin
         m_aborted = 1; exp_done = cyc; exp_start = -1;
      end
      // compare the DUT against the model for cycle cyc
      check_eq("stim_start", stim_start, cyc == exp_start);
      check_eq("done", done, cyc == exp_done);
      check_eq("busy", busy, m_busy);
      check_eq("aborted", aborted, m_aborted);
      check_eq("timeout_err", timeout_err, m_to);
      check_eq("frame_cnt", frame_cnt, m_frames % (1 << CW));
      check_eq("beat_cnt", beat_cnt, m_beats);
      if (stim_start) begin
         n_start_obs++; last_start_cyc = cyc;
         if (n_start_obs == 2) start2_cyc = cyc;
      end
      if (done) begin n_done_obs++; done_cyc = cyc; end
      if (cyc == exp_start) begin
         m_in_frame = 1; stall = 0; rdy_stall = 0;
         gen_left = $urandom_range(cfg_lmax, cfg_lmin);
      end
      // inputs for cycle cyc
      go = 1'b0;
      if (gen_left > 0) begin
         if (cfg_pct == 0) begin
            mon_tvalid = 1'b1; mon_tready = 1'b0;
         end else if (rdy_stall >= 3) begin
            mon_tvalid = 1'b1; mon_tready = 1'b1;
         end else begin
            mon_tvalid = ($urandom_range(99, 0) < 85);
            mon_tready = ($urandom_range(99, 0) < cfg_pct);
         end
         mon_tlast = (gen_left == 1);
         rdy_stall = (mon_tvalid && mon_tready) ? 0 : rdy_stall + 1;
      end else if (cfg_noise) begin
         mon_tvalid = 1'($urandom); mon_tready = 1'($urandom); mon_tlast = 1'($urandom);
      end else begin
         mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      end
      case (abort_mode)
         1: abort = m_busy && !m_in_frame && exp_done < 0 && m_frames >= abort_n && exp_start > cyc + 1;
         2: abort = m_in_frame && m_frames >= abort_n;
         3: abort = ($urandom_range(99, 0) < abort_pct) && (exp_start != cyc + 1);
         default: abort = 1'b0;
      endcase
   endtask

   task automatic run_seq(input int nf, input int gap);
      int k;
      n_start_obs = 0; n_done_obs = 0; start2_cyc = -1; done_cyc = -1; last_start_cyc = -1;
      num_frames = CW'(nf); gap_cycles = 16'(gap); go = 1'b1;
      step();
      num_frames = CW'($urandom); gap_cycles = 16'($urandom_range(15, 0));
      k = 0;
      while (m_busy && k < 3000) begin step(); k++; end
      check_eq("seq_ends", m_busy, 0);
      repeat (2) step();
   endtask

   task automatic pulse_reset();
      rstn = 1'b0; go = 1'b0; abort = 1'b0;
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      #1;
      check_eq("rst_async_busy", busy, 0);
      check_eq("rst_async_frame", frame_cnt, 0);
      @(negedge clk); cyc++;
      check_eq("rst_outputs", {stim_start, busy, done, aborted, timeout_err}, 0);
      check_eq("rst_counts", {frame_cnt, beat_cnt[27:0]}, 0);
      @(negedge clk); cyc++;
      reset_model();
      rstn = 1'b1;
   endtask

   initial begin
      int k;
      reset_model();
      @(negedge clk);
      check_eq("init_outputs", {stim_start, busy, done, aborted, timeout_err}, 0);
      check_eq("init_counts", beat_cnt, 0);
      @(negedge clk);
      rstn = 1'b1;

      // three 4-beat frames back to back
      cfg_lmin = 4; cfg_lmax = 4; cfg_pct = 100; cfg_noise = 0; abort_mode = 0;
      run_seq(3, 0);
      check_eq("s1_starts", n_start_obs, 3);
      check_eq("s1_frames", frame_cnt, 3);
      check_eq("s1_beats", beat_cnt, 12);
      check_eq("s1_dones", n_done_obs, 1);
      check_eq("s1_aborted", aborted, 0);

      // gap of 5: next start 7 cycles after the tlast beat
      cfg_lmin = 2; cfg_lmax = 5; cfg_pct = 70; cfg_noise = 1;
      run_seq(2, 5);
      check_eq("s2_start_lat", start2_cyc - first_tlast, 7);
      check_eq("s2_dones", n_done_obs, 1);
      check_eq("s2_frames", frame_cnt, 2);

      // continuous, aborted in the gap after 10 frames
      cfg_lmin = 1; cfg_lmax = 4; abort_mode = 1; abort_n = 10;
      run_seq(0, 3);
      check_eq("s3_aborted", aborted, 1);
      check_eq("s3_frames", frame_cnt, 10);
      check_eq("s3_dones", n_done_obs, 1);
      check_eq("s3_busy", busy, 0);

      // continuous 1-beat frames past the frame_cnt wrap
      cfg_lmin = 1; cfg_lmax = 1; cfg_pct = 100; abort_mode = 2; abort_n = 18;
      run_seq(0, 0);
      check_eq("s4_wrap", frame_cnt, m_frames % (1 << CW));
      check_eq("s4_aborted", aborted, 1);

`ifdef AXIS_STIM_SEQ_WDOG_EN
      // tready held low: watchdog ends the sequence
      cfg_lmin = 4; cfg_lmax = 4; cfg_pct = 0; cfg_noise = 0; abort_mode = 0;
      run_seq(1, 0);
      check_eq("s5_timeout", timeout_err, 1);
      check_eq("s5_done_lat", done_cyc - last_start_cyc, 17);
      check_eq("s5_frames", frame_cnt, 0);
`endif

      // go while busy, then reset in the middle of a gap
      cfg_lmin = 2; cfg_lmax = 3; cfg_pct = 90; cfg_noise = 1; abort_mode = 0;
      n_start_obs = 0; n_done_obs = 0;
      num_frames = CW'(3); gap_cycles = 16'd6; go = 1'b1;
      step();
      k = 0;
      while (!(n_tlast >= 1 && !m_in_frame && exp_start > cyc + 3) && k < 200) begin step(); k++; end
      check_eq("s6_in_gap", busy, 1);
      go = 1'b1;
      step();
      step();
      check_eq("s6_go_ignored", frame_cnt, 1);
      pulse_reset();
      check_eq("s6_no_done", n_done_obs, 0);
      run_seq(2, 1);
      check_eq("s6_restart_frames", frame_cnt, 2);
      check_eq("s6_restart_dones", n_done_obs, 1);

      // randomized sequences with sporadic aborts and bus noise
      abort_mode = 3; abort_pct = 3;
      for (int i = 0; i < 10; i++) begin
         cfg_lmin = 1; cfg_lmax = $urandom_range(6, 1);
         cfg_pct = $urandom_range(100, 50);
         run_seq($urandom_range(6, 1), $urandom_range(4, 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_stim_seq.md
AXIS_STIM_SEQ -- requirements
Module: axis_stim_seq

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the frame count fields.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, the number of stall cycles allowed before a watchdog timeout.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  sole clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the following control ports:
- go  in  1  one-cycle request to begin a sequence.
- abort  in  1  level; terminates an active sequence.
- num_frames  in  CNT_WIDTH  frames to run; 0 means continuous until abort.
- gap_cycles  in  16  idle cycles between frames.
REQ-005 SHALL have the following stimulus-generator and stream-monitor ports:
- stim_start  out  1  one-cycle start pulse to the stimulus generator.
- mon_tvalid / mon_tready / mon_tlast  in  1 each  passive tap of the generator's M_AXIS handshake.
REQ-006 SHALL have the following status ports:
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- aborted  out  1  sticky; set when the sequence ended by abort.
- timeout_err  out  1  sticky watchdog flag.
- frame_cnt  out  CNT_WIDTH  frames completed.
- beat_cnt  out  32  total accepted beats.

Function
REQ-007 SHALL implement the states IDLE, START, WAIT_LAST, GAP and DONE, and all outputs SHALL be registered.
REQ-008 IDLE: on go=1 SHALL latch num_frames and gap_cycles, clear frame_cnt, beat_cnt, aborted and timeout_err, and go to START.
REQ-009 START: SHALL assert stim_start for exactly one cycle, clear the watchdog, and go to WAIT_LAST.
REQ-010 WAIT_LAST: SHALL increment beat_cnt on every cycle with mon_tvalid&mon_tready; beat_cnt SHALL wrap at 2^32.
REQ-011 WAIT_LAST: a beat with mon_tlast=1 SHALL increment frame_cnt, then branch:
- DONE if the new count equals a non-zero num_frames;
- else START if gap_cycles=0;
- else GAP.
REQ-012 Timing: with a tlast beat at cycle T, stim_start for the next frame SHALL be high in cycle T+2+gap_cycles (T+2 when gap_cycles=0).
REQ-013 GAP: SHALL load a down-counter with gap_cycles on entry and go to START when it reaches 0.
REQ-014 Continuous mode (num_frames=0): frame_cnt SHALL wrap from 2^CNT_WIDTH-1 to 0 and the sequence SHALL continue.
REQ-015 DONE: SHALL assert done for one cycle, then return to IDLE; busy SHALL be 0 in IDLE only.
REQ-016 abort=1 in START, WAIT_LAST or GAP SHALL set aborted and go to DONE next cycle; a tlast beat coinciding with abort SHALL still be counted.
REQ-017 go SHALL be ignored while busy=1, and abort SHALL be ignored in IDLE and DONE.
REQ-018 Handshake counting SHALL occur only in WAIT_LAST; beats in other states SHALL be ignored.

Reset
REQ-019 rstn=0 SHALL force IDLE immediately and clear all outputs: stim_start=0, busy=0, done=0, aborted=0, timeout_err=0, frame_cnt=0, beat_cnt=0.
REQ-020 Reset asserted mid-sequence SHALL abandon the sequence without a done pulse, and the block SHALL accept go from the first clk edge after rstn deasserts.

Configuration
REQ-021 Macro AXIS_STIM_SEQ_WDOG_EN SHALL control the watchdog.
- Defined: in WAIT_LAST a counter SHALL count cycles without a handshake (reset on each handshake); on reaching TIMEOUT_CYC it SHALL set timeout_err and go to DONE.
- Undefined: timeout_err SHALL be tied to 0 and WAIT_LAST SHALL wait indefinitely.

Verification
REQ-023 The bench SHALL cover:
- num_frames=3, gap_cycles=0, 4-beat frames, tready=1: exactly 3 stim_start pulses, frame_cnt=3, beat_cnt=12, one done, aborted=0.
- num_frames=2, gap_cycles=5, tlast at cycle T: second stim_start high at T+7, done after frame 2.
- num_frames=0, continuous, abort after 10 frames: aborted=1, done pulse, frame_cnt=10, busy=0 the cycle after DONE.
- AXIS_STIM_SEQ_WDOG_EN defined, TIMEOUT_CYC=16, tready held 0: timeout_err=1 and done asserted 17 cycles after entering WAIT_LAST.
- go pulsed while busy, then rstn pulsed low mid-GAP: second go ignored; all outputs 0 and no done pulse; a new go after reset starts cleanly.
